// File: rtl/regfile_port_arbiter_pkg.sv
// Shared constants and types for the register-file port arbiter.
//   DW        data width, must match the register file
//   AW        register address width (2**AW registers)
//   REG_ZERO  hard-zero register index
//   REQ_CORE  requester index of the core datapath
//   REQ_DBG   requester index of the debug/loader port
package regfile_port_arbiter_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;

    localparam int unsigned REQ_CORE = 0;
    localparam int unsigned REQ_DBG  = 1;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] reg_data_t;

endpackage

// File: rtl/regfile_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk  rising-edge clock
//   rst  synchronous active-high reset; forces gnt low and pointer to REQ_CORE
//   req  request vector, bit i = requester i
//   gnt  one-hot (or zero) grant vector, combinational from req
// The pointer names the requester preferred on contention and only moves when both request.
module rr_arb2
    import regfile_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (!rst) begin
            case (req)
                2'b01:   gnt[REQ_CORE] = 1'b1;
                2'b10:   gnt[REQ_DBG]  = 1'b1;
                2'b11: begin
                    if (ptr_q) gnt[REQ_DBG]  = 1'b1;
                    else       gnt[REQ_CORE] = 1'b1;
                    ptr_d = ~ptr_q;
                end
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares a 2R1W register file between two requesters.
//   Clk, Rst                 clock, synchronous active-high reset
//   RdReq*/RdAddr*           per-requester read request (pulse) and address
//   RdValid*/RdData*         registered read response, one cycle after RdReq
//   WrReq*/WrAddr*/WrData*   write request, held until WrGnt
//   WrGnt*                   combinational write grant
//   Ard1/Ard2, Dout1/Dout2   regfile read ports (requester 0 -> port 1, requester 1 -> port 2)
//   Awr/Din/WrEn             regfile write port, driven from the registered W stage
module regfile_port_arbiter #(
    parameter int unsigned DW = regfile_port_arbiter_pkg::DW,
    parameter int unsigned AW = regfile_port_arbiter_pkg::AW
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          RdReq0,
    input  logic [AW-1:0] RdAddr0,
    output logic          RdValid0,
    output logic [DW-1:0] RdData0,
    input  logic          RdReq1,
    input  logic [AW-1:0] RdAddr1,
    output logic          RdValid1,
    output logic [DW-1:0] RdData1,
    input  logic          WrReq0,
    input  logic [AW-1:0] WrAddr0,
    input  logic [DW-1:0] WrData0,
    input  logic          WrReq1,
    input  logic [AW-1:0] WrAddr1,
    input  logic [DW-1:0] WrData1,
    output logic          WrGnt0,
    output logic          WrGnt1,
    output logic [AW-1:0] Ard1,
    output logic [AW-1:0] Ard2,
    input  logic [DW-1:0] Dout1,
    input  logic [DW-1:0] Dout2,
    output logic [AW-1:0] Awr,
    output logic [DW-1:0] Din,
    output logic          WrEn
);

    import regfile_port_arbiter_pkg::*;

    localparam logic [AW-1:0] Zero = AW'(REG_ZERO);

    logic [1:0]    gnt;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    logic          w_valid_q;
    logic [AW-1:0] awr_q;
    logic [DW-1:0] din_q;

    logic          rd_valid0_q, rd_valid1_q;
    logic [DW-1:0] rd_data0_q, rd_data1_q;
    logic [DW-1:0] rd_data0_d, rd_data1_d;

    assign Ard1 = RdAddr0;
    assign Ard2 = RdAddr1;

    rr_arb2 u_arb (
        .clk (Clk),
        .rst (Rst),
        .req ({WrReq1, WrReq0}),
        .gnt (gnt)
    );

    assign WrGnt0 = gnt[REQ_CORE];
    assign WrGnt1 = gnt[REQ_DBG];

    always_comb begin
        sel_addr = WrAddr0;
        sel_data = WrData0;
        if (gnt[REQ_DBG]) begin
            sel_addr = WrAddr1;
            sel_data = WrData1;
        end
    end

    // W stage: a write to r0 is granted but never becomes valid, so it never commits.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            w_valid_q <= 1'b0;
            awr_q     <= '0;
            din_q     <= '0;
        end else if (|gnt) begin
            w_valid_q <= (sel_addr != Zero);
            awr_q     <= sel_addr;
            din_q     <= sel_data;
        end else begin
            w_valid_q <= 1'b0;
        end
    end

    // Gating with Rst keeps a write already in the W stage from committing during reset.
    assign WrEn = w_valid_q & ~Rst;
    assign Awr  = awr_q;
    assign Din  = din_q;

    // The regfile only commits at the end of the W cycle, so Dout is stale for that
    // address; forward Din instead. r0 is forced to zero.
    always_comb begin
        rd_data0_d = Dout1;
        if (RdAddr0 == Zero)                       rd_data0_d = '0;
        else if (w_valid_q && (awr_q == RdAddr0)) rd_data0_d = din_q;

        rd_data1_d = Dout2;
        if (RdAddr1 == Zero)                       rd_data1_d = '0;
        else if (w_valid_q && (awr_q == RdAddr1)) rd_data1_d = din_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_valid0_q <= 1'b0;
            rd_valid1_q <= 1'b0;
            rd_data0_q  <= '0;
            rd_data1_q  <= '0;
        end else begin
            rd_valid0_q <= RdReq0;
            rd_valid1_q <= RdReq1;
            if (RdReq0) rd_data0_q <= rd_data0_d;
            if (RdReq1) rd_data1_q <= rd_data1_d;
        end
    end

    assign RdValid0 = rd_valid0_q;
    assign RdValid1 = rd_valid1_q;
    assign RdData0  = rd_data0_q;
    assign RdData1  = rd_data1_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: per-cycle stimulus table with expected grants, a
// behavioural 32x32 regfile, and a shadow architectural model feeding read scoreboards.
module tb_regfile_port_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        RdReq0, RdReq1, WrReq0, WrReq1;
    logic [4:0]  RdAddr0, RdAddr1, WrAddr0, WrAddr1;
    logic [31:0] WrData0, WrData1;
    logic        RdValid0, RdValid1, WrGnt0, WrGnt1, WrEn;
    logic [31:0] RdData0, RdData1, Dout1, Dout2, Din;
    logic [4:0]  Ard1, Ard2, Awr;

    regfile_port_arbiter dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .RdReq0   (RdReq0),
        .RdAddr0  (RdAddr0),
        .RdValid0 (RdValid0),
        .RdData0  (RdData0),
        .RdReq1   (RdReq1),
        .RdAddr1  (RdAddr1),
        .RdValid1 (RdValid1),
        .RdData1  (RdData1),
        .WrReq0   (WrReq0),
        .WrAddr0  (WrAddr0),
        .WrData0  (WrData0),
        .WrReq1   (WrReq1),
        .WrAddr1  (WrAddr1),
        .WrData1  (WrData1),
        .WrGnt0   (WrGnt0),
        .WrGnt1   (WrGnt1),
        .Ard1     (Ard1),
        .Ard2     (Ard2),
        .Dout1    (Dout1),
        .Dout2    (Dout2),
        .Awr      (Awr),
        .Din      (Din),
        .WrEn     (WrEn)
    );

    always #5 Clk = ~Clk;

    // Behavioural regfile: combinational read, commit on the rising edge.
    logic [31:0] rf [32];
    logic        rf_load;
    always @(posedge Clk) begin
        if (rf_load) begin
            for (int k = 0; k < 32; k++) rf[k] <= (k == 0) ? 32'h0 : 32'(32'h100 + k);
        end else if (WrEn) begin
            rf[Awr] <= Din;
        end
    end
    assign Dout1 = rf[Ard1];
    assign Dout2 = rf[Ard2];

    typedef struct {
        logic        rst;
        logic        rr0;
        logic [4:0]  ra0;
        logic        rr1;
        logic [4:0]  ra1;
        logic        w0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        w1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        g0;
        logic        g1;
    } vec_t;

    vec_t vecs[$];

    // Shadow model: committed state plus the pending W-stage write.
    logic [31:0] arch [32];
    logic        pend_v;
    logic [4:0]  pend_a;
    logic [31:0] pend_d;
    logic        exp_rv0, exp_rv1;
    logic [31:0] last0, last1;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    int checks   = 0;
    int failures = 0;
    int cur_row  = -1;

    task automatic add(input logic rst, input logic rr0, input logic [4:0] ra0,
                       input logic rr1, input logic [4:0] ra1,
                       input logic w0, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic w1, input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic g0, input logic g1);
        vec_t v;
        v.rst = rst; v.rr0 = rr0; v.ra0 = ra0; v.rr1 = rr1; v.ra1 = ra1;
        v.w0 = w0; v.wa0 = wa0; v.wd0 = wd0; v.w1 = w1; v.wa1 = wa1; v.wd1 = wd1;
        v.g0 = g0; v.g1 = g1;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL row %0d %s: got %h expected %h", cur_row, name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (pend_v && pend_a == a) return pend_d;
        return arch[a];
    endfunction

    task automatic check_read(input string name, input logic valid, input logic [31:0] data,
                              input logic exp_rv, inout logic [31:0] last,
                              inout logic [31:0] q[$]);
        logic [31:0] e;
        check({name, "_valid"}, {31'b0, valid}, {31'b0, exp_rv});
        if (exp_rv) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL row %0d %s_queue: got empty expected entry", cur_row, name);
            end else begin
                e = q.pop_front();
                check({name, "_data"}, data, e);
                last = e;
            end
        end else begin
            check({name, "_hold"}, data, last);
        end
    endtask

    initial begin
        vec_t v;
        Rst = 1'b1; rf_load = 1'b1;
        RdReq0 = 0; RdReq1 = 0; WrReq0 = 0; WrReq1 = 0;
        RdAddr0 = 0; RdAddr1 = 0; WrAddr0 = 0; WrAddr1 = 0; WrData0 = 0; WrData1 = 0;
        for (int k = 0; k < 32; k++) arch[k] = (k == 0) ? 32'h0 : 32'(32'h100 + k);
        pend_v = 0; pend_a = 0; pend_d = 0;
        exp_rv0 = 0; exp_rv1 = 0; last0 = 0; last1 = 0;

        //   rst rr0 ra0  rr1 ra1  w0 wa0 wd0           w1 wa1 wd1           g0 g1
        // Reset held with a pending write request and reads: nothing granted or valid.
        add(1, 1, 5'd2, 1, 5'd6, 1, 5'd3, 32'h33,       0, 5'd0, 32'h0,        0, 0);
        add(1, 1, 5'd2, 0, 5'd0, 1, 5'd3, 32'h33,       0, 5'd0, 32'h0,        0, 0);
        // First grant after release goes to requester 0; same-cycle read sees old r3.
        add(0, 1, 5'd3, 0, 5'd0, 1, 5'd3, 32'h33,       0, 5'd0, 32'h0,        1, 0);
        add(0, 1, 5'd3, 0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0);
        add(0, 0, 5'd0, 1, 5'd3, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0);
        // Contention for four cycles: 0,1,0,1.
        add(0, 0, 5'd0, 0, 5'd0, 1, 5'd8, 32'h80,       1, 5'd9, 32'h90,       1, 0);
        add(0, 0, 5'd0, 0, 5'd0, 1, 5'd10, 32'hA0,      1, 5'd9, 32'h90,       0, 1);
        add(0, 0, 5'd0, 0, 5'd0, 1, 5'd10, 32'hA0,      1, 5'd11, 32'hB0,      1, 0);
        add(0, 0, 5'd0, 0, 5'd0, 1, 5'd12, 32'hC0,      1, 5'd11, 32'hB0,      0, 1);
        add(0, 1, 5'd8, 1, 5'd11, 1, 5'd12, 32'hC0,     0, 5'd0, 32'h0,        1, 0);
        // Uncontested grant does not move the pointer.
        add(0, 1, 5'd12, 0, 5'd0, 0, 5'd0, 32'h0,       1, 5'd13, 32'hD0,      0, 1);
        add(0, 0, 5'd0, 1, 5'd13, 1, 5'd14, 32'hE0,     1, 5'd15, 32'hF0,      1, 0);
        add(0, 1, 5'd14, 0, 5'd0, 0, 5'd0, 32'h0,       1, 5'd15, 32'hF0,      0, 1);
        // Forwarding: read in grant cycle sees old r5, read one cycle later sees new.
        add(0, 1, 5'd5, 0, 5'd0, 0, 5'd0, 32'h0,        1, 5'd5, 32'hDEADBEEF, 0, 1);
        add(0, 1, 5'd5, 1, 5'd15, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,        0, 0);
        // r0 write is acknowledged but never commits.
        add(0, 0, 5'd0, 0, 5'd0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0,        1, 0);
        add(0, 1, 5'd0, 1, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0);
        add(0, 0, 5'd0, 1, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0);
        // Reset in the W cycle discards r7=0x1234; pointer returns to requester 0.
        add(0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 32'h1234,     0, 5'd0, 32'h0,        1, 0);
        add(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,        0, 0);
        add(0, 1, 5'd7, 0, 5'd0, 1, 5'd16, 32'h1600,    1, 5'd17, 32'h1700,    1, 0);
        add(0, 0, 5'd0, 1, 5'd7, 0, 5'd0, 32'h0,        1, 5'd17, 32'h1700,    0, 1);
        // Back-to-back writes r1..r4, reads lagging two cycles.
        add(0, 0, 5'd0, 0, 5'd0, 1, 5'd1, 32'h1,        0, 5'd0, 32'h0,        1, 0);
        add(0, 0, 5'd0, 0, 5'd0, 1, 5'd2, 32'h2,        0, 5'd0, 32'h0,        1, 0);
        add(0, 0, 5'd0, 1, 5'd1, 1, 5'd3, 32'h3,        0, 5'd0, 32'h0,        1, 0);
        add(0, 0, 5'd0, 1, 5'd2, 1, 5'd4, 32'h4,        0, 5'd0, 32'h0,        1, 0);
        add(0, 1, 5'd4, 1, 5'd3, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0);
        add(0, 1, 5'd16, 1, 5'd4, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,        0, 0);
        add(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0);

        @(posedge Clk);
        #1 rf_load = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            cur_row = i;
            @(posedge Clk);
            #1;
            Rst = v.rst;
            RdReq0 = v.rr0; RdAddr0 = v.ra0; RdReq1 = v.rr1; RdAddr1 = v.ra1;
            WrReq0 = v.w0; WrAddr0 = v.wa0; WrData0 = v.wd0;
            WrReq1 = v.w1; WrAddr1 = v.wa1; WrData1 = v.wd1;
            #1;
            check("wrgnt0", {31'b0, WrGnt0}, {31'b0, v.g0});
            check("wrgnt1", {31'b0, WrGnt1}, {31'b0, v.g1});
            check("ard1", {27'b0, Ard1}, {27'b0, v.ra0});
            check("ard2", {27'b0, Ard2}, {27'b0, v.ra1});
            check("wren", {31'b0, WrEn}, {31'b0, pend_v && !v.rst});
            if (pend_v && !v.rst) begin
                check("awr", {27'b0, Awr}, {27'b0, pend_a});
                check("din", Din, pend_d);
            end
            check_read("rd0", RdValid0, RdData0, exp_rv0, last0, q0);
            check_read("rd1", RdValid1, RdData1, exp_rv1, last1, q1);

            // Advance the model: reads see state before this cycle's grant.
            if (v.rst) begin
                exp_rv0 = 0; exp_rv1 = 0; last0 = 0; last1 = 0;
                q0.delete(); q1.delete();
                pend_v = 0;
            end else begin
                exp_rv0 = v.rr0;
                exp_rv1 = v.rr1;
                if (v.rr0) q0.push_back(model_read(v.ra0));
                if (v.rr1) q1.push_back(model_read(v.ra1));
                if (pend_v) arch[pend_a] = pend_d;
                pend_v = 0;
                if (v.g0) begin
                    pend_v = (v.wa0 != 5'd0); pend_a = v.wa0; pend_d = v.wd0;
                end else if (v.g1) begin
                    pend_v = (v.wa1 != 5'd0); pend_a = v.wa1; pend_d = v.wd1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
